// File: rtl/evr_pulse_gen.sv
// evr_pulse_gen
//   Decodes the EVR event code on app_clk and drives NUM_OUT delayed,
//   programmable-width trigger pulses. Each channel has its own event code,
//   delay and width, all configured through a word-addressed register port.
//
// Ports
//   app_clk     application clock
//   app_rst     synchronous active-high reset
//   ev          event code from the EVR, 0 = no event
//   reg_wr      register write strobe (1 cycle)
//   reg_rd      register read strobe (1 cycle)
//   reg_addr    byte address, addr[1:0] ignored
//   reg_wdata   write data
//   reg_rdata   read data, valid with reg_rvalid
//   reg_rvalid  read response, one cycle after reg_rd
//   pulse_out   registered trigger outputs (active ^ pol)
//
// Register map
//   0x10*c + 0x0  CTRL   bit0 ena, bit1 pol
//   0x10*c + 0x4  CODE   [7:0]
//   0x10*c + 0x8  DELAY  [DLY_W-1:0]
//   0x10*c + 0xC  WIDTH  [WID_W-1:0]
//   0x40 + 4*c    MISSED [15:0], read-only, any write clears
//   0x50          STATUS bit c = channel c busy
//
// Channel FSM
//   state  | meaning
//   S_IDLE | waiting for a matching event
//   S_DLY  | counting the latched DELAY
//   S_PLS  | output active, counting the latched WIDTH
module evr_pulse_gen #(
  parameter int NUM_OUT = 4,
  parameter int DLY_W   = 32,
  parameter int WID_W   = 16
) (
  input  logic               app_clk,
  input  logic               app_rst,
  input  logic [7:0]         ev,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [7:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_rvalid,
  output logic [NUM_OUT-1:0] pulse_out
);

  localparam int CW = (DLY_W > WID_W) ? DLY_W : WID_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DLY  = 2'd1,
    S_PLS  = 2'd2
  } state_t;

  // Configuration
  logic             ena_q  [NUM_OUT];
  logic             pol_q  [NUM_OUT];
  logic [7:0]       code_q [NUM_OUT];
  logic [DLY_W-1:0] dly_q  [NUM_OUT];
  logic [WID_W-1:0] wid_q  [NUM_OUT];
  logic [15:0]      miss_q [NUM_OUT];

  // Channel state
  state_t           st_q   [NUM_OUT];
  logic [CW-1:0]    cnt_q  [NUM_OUT];
  logic [WID_W-1:0] wl_q   [NUM_OUT];

  // Next-state values
  state_t           st_n   [NUM_OUT];
  logic [CW-1:0]    cnt_n  [NUM_OUT];
  logic [WID_W-1:0] wl_n   [NUM_OUT];
  logic [15:0]      miss_n [NUM_OUT];
  logic [NUM_OUT-1:0] pulse_n;

  logic [NUM_OUT-1:0] wr_ch;
  logic [NUM_OUT-1:0] wr_ctrl;
  logic [NUM_OUT-1:0] wr_miss;
  logic [NUM_OUT-1:0] match;
  logic [31:0]        rd_mux;

  logic [1:0] sub;
  logic       chan_space;
  logic       miss_space;
  logic       stat_sel;

  assign sub        = reg_addr[3:2];
  assign chan_space = (reg_addr[7:6] == 2'b00);
  assign miss_space = (reg_addr[7:4] == 4'h4);
  assign stat_sel   = (reg_addr[7:2] == 6'h14);

  logic unused_bits;
  assign unused_bits = ^{reg_addr[1:0], reg_wdata};

  // Write decode; channels beyond NUM_OUT simply never match.
  always_comb begin
    for (int c = 0; c < NUM_OUT; c++) begin
      wr_ch[c]   = reg_wr && chan_space && (reg_addr[5:4] == 2'(c));
      wr_ctrl[c] = wr_ch[c] && (sub == 2'd0);
      wr_miss[c] = reg_wr && miss_space && (sub == 2'(c));
      match[c]   = ena_q[c] && (code_q[c] != 8'd0) && (ev == code_q[c]);
    end
  end

  // Channel next-state. pulse_out is registered from the next state so the
  // output is active in exactly the cycles the FSM spends in S_PLS.
  always_comb begin
    for (int c = 0; c < NUM_OUT; c++) begin
      st_n[c]   = st_q[c];
      cnt_n[c]  = cnt_q[c];
      wl_n[c]   = wl_q[c];
      miss_n[c] = miss_q[c];

      case (st_q[c])
        S_IDLE: begin
          if (match[c] && (wid_q[c] != '0)) begin
            if (dly_q[c] != '0) begin
              st_n[c]  = S_DLY;
              cnt_n[c] = CW'(dly_q[c]);
              wl_n[c]  = wid_q[c];
            end else begin
              st_n[c]  = S_PLS;
              cnt_n[c] = CW'(wid_q[c]);
            end
          end
        end
        S_DLY: begin
          if (cnt_q[c] == CW'(1)) begin
            st_n[c]  = S_PLS;
            cnt_n[c] = CW'(wl_q[c]);
          end else begin
            cnt_n[c] = cnt_q[c] - CW'(1);
          end
        end
        S_PLS: begin
          if (cnt_q[c] == CW'(1)) st_n[c] = S_IDLE;
          else                    cnt_n[c] = cnt_q[c] - CW'(1);
        end
        default: st_n[c] = S_IDLE;
      endcase

      // A busy channel that sees its code again records the miss.
      if ((st_q[c] != S_IDLE) && match[c] && (miss_q[c] != 16'hFFFF))
        miss_n[c] = miss_q[c] + 16'd1;
      if (wr_miss[c])
        miss_n[c] = 16'd0;

      // Clearing ena aborts whatever the channel is doing.
      if (wr_ctrl[c] && !reg_wdata[0])
        st_n[c] = S_IDLE;

      pulse_n[c] = (st_n[c] == S_PLS) ^ (wr_ctrl[c] ? reg_wdata[1] : pol_q[c]);
    end
  end

  // Read mux works on current register values, so a same-cycle write is
  // not visible to the read.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_OUT; c++) begin
      if (chan_space && (reg_addr[5:4] == 2'(c))) begin
        case (sub)
          2'd0: rd_mux[1:0]       = {pol_q[c], ena_q[c]};
          2'd1: rd_mux[7:0]       = code_q[c];
          2'd2: rd_mux[DLY_W-1:0] = dly_q[c];
          2'd3: rd_mux[WID_W-1:0] = wid_q[c];
          default: rd_mux = '0;
        endcase
      end
      if (miss_space && (sub == 2'(c)))
        rd_mux[15:0] = miss_q[c];
      if (stat_sel)
        rd_mux[c] = (st_q[c] != S_IDLE);
    end
  end

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      reg_rvalid <= 1'b0;
      reg_rdata  <= '0;
      pulse_out  <= '0;
      for (int c = 0; c < NUM_OUT; c++) begin
        ena_q[c]  <= 1'b0;
        pol_q[c]  <= 1'b0;
        code_q[c] <= '0;
        dly_q[c]  <= '0;
        wid_q[c]  <= '0;
        miss_q[c] <= '0;
        st_q[c]   <= S_IDLE;
        cnt_q[c]  <= '0;
        wl_q[c]   <= '0;
      end
    end else begin
      reg_rvalid <= reg_rd;
      reg_rdata  <= reg_rd ? rd_mux : '0;
      pulse_out  <= pulse_n;
      for (int c = 0; c < NUM_OUT; c++) begin
        if (wr_ch[c]) begin
          case (sub)
            2'd0: begin
              ena_q[c] <= reg_wdata[0];
              pol_q[c] <= reg_wdata[1];
            end
            2'd1: code_q[c] <= reg_wdata[7:0];
            2'd2: dly_q[c]  <= reg_wdata[DLY_W-1:0];
            2'd3: wid_q[c]  <= reg_wdata[WID_W-1:0];
            default: ;
          endcase
        end
        st_q[c]   <= st_n[c];
        cnt_q[c]  <= cnt_n[c];
        wl_q[c]   <= wl_n[c];
        miss_q[c] <= miss_n[c];
      end
    end
  end

endmodule

// File: tb/tb_evr_pulse_gen.sv
// Bench for evr_pulse_gen with three channels, so channel 3 is unmapped.
// Expected pulse_out bits and read responses are queued with the cycle they
// are due and compared as the DUT produces them.
module tb_evr_pulse_gen;

  localparam int N = 3;

  logic         app_clk = 1'b0;
  logic         app_rst = 1'b1;
  logic [7:0]   ev = '0;
  logic         reg_wr = 1'b0;
  logic         reg_rd = 1'b0;
  logic [7:0]   reg_addr = '0;
  logic [31:0]  reg_wdata = '0;
  logic [31:0]  reg_rdata;
  logic         reg_rvalid;
  logic [N-1:0] pulse_out;

  evr_pulse_gen #(.NUM_OUT(N), .DLY_W(32), .WID_W(16)) dut (
    .app_clk   (app_clk),
    .app_rst   (app_rst),
    .ev        (ev),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_rvalid(reg_rvalid),
    .pulse_out (pulse_out)
  );

  always #5 app_clk = ~app_clk;

  int cyc = 0;
  always @(posedge app_clk) cyc <= cyc + 1;

  typedef struct { int cyc; int ch; logic val; } bit_exp_t;
  typedef struct { int cyc; logic [31:0] data; string tag; } rd_exp_t;

  bit_exp_t pq[$];
  rd_exp_t  rq[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge app_clk) begin
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].cyc == cyc) begin
        check_val($sformatf("pulse_out[%0d]", pq[i].ch), 32'(pulse_out[pq[i].ch]), 32'(pq[i].val));
        pq.delete(i);
      end
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      check_val({rq[0].tag, "_rvalid"}, 32'(reg_rvalid), 32'd1);
      check_val(rq[0].tag, reg_rdata, rq[0].data);
      void'(rq.pop_front());
    end else if (!app_rst) begin
      check_val("rvalid_idle", 32'(reg_rvalid), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge app_clk);
      #1;
    end
  endtask

  task automatic push_bit(input int ch, input int c, input logic v);
    bit_exp_t e;
    e.cyc = c; e.ch = ch; e.val = v;
    pq.push_back(e);
  endtask

  // Expected output around a trigger at cycle t: active over t+1+d .. t+d+w.
  task automatic push_pulse(input int ch, input int t, input int d, input int w, input logic pol);
    for (int k = 1; k <= d + w + 2; k++)
      push_bit(ch, t + k, ((k >= d + 1) && (k <= d + w)) ^ pol);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick(1);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    rd_exp_t e;
    e.cyc = cyc + 1; e.data = exp; e.tag = tag;
    rq.push_back(e);
    reg_rd = 1'b1; reg_addr = a;
    tick(1);
    reg_rd = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] a, input logic [31:0] d, input logic [31:0] old, input string tag);
    rd_exp_t e;
    e.cyc = cyc + 1; e.data = old; e.tag = tag;
    rq.push_back(e);
    reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick(1);
    reg_rd = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic fire(input logic [7:0] code, output int t);
    ev = code;
    t = cyc;
    tick(1);
    ev = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int t;
    int t2;

    // Reset state
    tick(3);
    app_rst = 1'b0;
    check_val("rst_pulse_out", 32'(pulse_out), 32'd0);
    check_val("rst_rvalid", 32'(reg_rvalid), 32'd0);
    check_val("rst_rdata", reg_rdata, 32'd0);
    rd(8'h00, 32'd0, "rst_ctrl0");
    rd(8'h08, 32'd0, "rst_delay0");
    rd(8'h40, 32'd0, "rst_missed0");
    rd(8'h50, 32'd0, "rst_status");

    // Ch0: CODE=0x21, DELAY=5, WIDTH=3
    wr(8'h04, 32'h0000_0021);
    rdwr(8'h08, 32'd5, 32'd0, "rdwr_old");
    rd(8'h08, 32'd5, "delay0");
    wr(8'h0C, 32'hFFFF_0003);
    rd(8'h0C, 32'd3, "width0_mask");
    rd(8'h04, 32'h21, "code0");
    wr(8'h00, 32'h1);
    fire(8'h21, t);
    push_pulse(0, t, 5, 3, 1'b0);
    rd(8'h50, 32'h1, "status_dly");
    tick(12);

    // Ch1: DELAY=0, WIDTH=1, pol=1
    wr(8'h14, 32'h33);
    wr(8'h18, 32'd0);
    wr(8'h1C, 32'd1);
    push_bit(1, cyc, 1'b0);
    push_bit(1, cyc + 1, 1'b1);
    wr(8'h10, 32'h3);
    fire(8'h33, t);
    push_pulse(1, t, 0, 1, 1'b1);
    tick(5);

    // Ch0 retrigger during delay: DELAY=10, WIDTH=4
    wr(8'h08, 32'd10);
    wr(8'h0C, 32'd4);
    fire(8'h21, t);
    push_pulse(0, t, 10, 4, 1'b0);
    tick(2);
    fire(8'h21, t2);
    tick(14);
    rd(8'h40, 32'd1, "missed_one");
    wr(8'h40, 32'hDEAD_BEEF);
    rd(8'h40, 32'd0, "missed_clr");
    rd(8'h44, 32'd0, "missed_ch1");

    // Re-arm boundary: the last active cycle misses, the next one triggers
    wr(8'h08, 32'd2);
    wr(8'h0C, 32'd2);
    fire(8'h21, t);
    push_pulse(0, t, 2, 2, 1'b0);
    tick(3);
    fire(8'h21, t2);
    fire(8'h21, t2);
    push_pulse(0, t2, 2, 2, 1'b0);
    tick(8);
    rd(8'h40, 32'd1, "missed_boundary");

    // Ch0 and ch2 share CODE=0x05 with different schedules
    wr(8'h04, 32'h05);
    wr(8'h24, 32'h05);
    wr(8'h28, 32'd7);
    wr(8'h2C, 32'd3);
    wr(8'h20, 32'h1);
    fire(8'h05, t);
    push_pulse(0, t, 2, 2, 1'b0);
    push_pulse(2, t, 7, 3, 1'b0);
    for (int k = 1; k <= 4; k++) push_bit(1, t + k, 1'b1);
    tick(13);

    // ev=0 with CODE=0 on ch2: nothing fires
    wr(8'h24, 32'h00);
    fire(8'h00, t);
    push_pulse(0, t, 5, 0, 1'b0);
    push_pulse(2, t, 5, 0, 1'b0);
    tick(8);
    rd(8'h50, 32'd0, "status_quiet");

    // WIDTH=0 trigger: no pulse, not a miss
    wr(8'h0C, 32'd0);
    wr(8'h08, 32'd3);
    fire(8'h05, t);
    push_pulse(0, t, 5, 0, 1'b0);
    tick(8);
    rd(8'h40, 32'd1, "missed_w0");

    // Abort during a long pulse
    wr(8'h04, 32'h21);
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd100);
    fire(8'h21, t);
    for (int k = 1; k <= 5; k++) push_bit(0, t + k, 1'b1);
    rd(8'h50, 32'h1, "status_pls");
    tick(3);
    for (int k = 6; k <= 9; k++) push_bit(0, t + k, 1'b0);
    wr(8'h00, 32'h0);
    rd(8'h50, 32'h0, "status_abort");
    tick(4);

    // Reset in the middle of a pulse
    wr(8'h00, 32'h1);
    fire(8'h21, t);
    for (int k = 1; k <= 3; k++) push_bit(0, t + k, 1'b1);
    tick(2);
    for (int k = 4; k <= 7; k++)
      for (int ch = 0; ch < N; ch++) push_bit(ch, t + k, 1'b0);
    app_rst = 1'b1;
    tick(2);
    app_rst = 1'b0;
    tick(2);
    rd(8'h00, 32'd0, "post_rst_ctrl0");
    rd(8'h0C, 32'd0, "post_rst_width0");
    rd(8'h14, 32'd0, "post_rst_code1");
    rd(8'h40, 32'd0, "post_rst_missed0");
    rd(8'h50, 32'd0, "post_rst_status");

    // Unmapped space
    wr(8'h34, 32'h55);
    rd(8'h34, 32'd0, "ch3_code");
    rd(8'h3C, 32'd0, "ch3_width");
    rd(8'h4C, 32'd0, "ch3_missed");
    wr(8'h60, 32'hFFFF_FFFF);
    rd(8'h60, 32'd0, "addr_60");

    tick(4);
    check_val("pulse_queue_drained", 32'(pq.size()), 32'd0);
    check_val("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
